// File: rtl/fir_output_stage.sv
// fir_output_stage: output stage of the FIR datapath.
// Registers each completed accumulator sum, rounds and rescales it from Q-format,
// saturates it to the sample width, and queues the result in a show-ahead FIFO
// behind a valid/ready handshake.
// Build option FIR_OUT_ROUND_EN: when defined, add 2^(Shift-1) before the
// arithmetic shift (round half toward +inf). When undefined, truncate toward -inf.
module fir_output_stage #(
    parameter int AccWidth    = 38,
    parameter int OutputWidth = 16,
    parameter int Shift       = 15,
    parameter int Depth       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AccWidth-1:0]      acc_in,
    input  logic                     acc_valid,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [OutputWidth-1:0]   dout,
    output logic                     dout_sat,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(Depth):0]   level,
    output logic                     overflow
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

    // Saturation bounds, expressed at the full width of the shifted sum.
    localparam logic signed [AccWidth:0] MaxQ =
        {{(AccWidth - OutputWidth + 2){1'b0}}, {(OutputWidth - 1){1'b1}}};
    localparam logic signed [AccWidth:0] MinQ = ~MaxQ;
`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [AccWidth:0] RoundOff =
        {{AccWidth{1'b0}}, 1'b1} << (Shift - 1);
`endif

    // Stage A registers.
    logic                a_valid_q;
    logic [AccWidth-1:0] a_q;

    // Stage B combinational results.
    logic signed [AccWidth:0] sum_b;
    logic signed [AccWidth:0] q_b;
    logic [OutputWidth-1:0]   q_sat_b;
    logic                     sat_b;
    logic [OutputWidth:0]     push_word;

    // FIFO state. Each entry is {sat, sample}.
    logic [OutputWidth:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [OutputWidth:0] out_q, out_d;

    // FIFO control strobes.
    logic            push, pop, full, accept, drop;
    logic [PtrW-1:0] head_idx;
    logic [OutputWidth:0] head_word;

    // Stage A: capture a completed accumulator sum. Flush discards the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q <= 1'b0;
            a_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            a_valid_q <= acc_valid && !flush;
            if (acc_valid) begin
                a_q <= acc_in;
            end
        end
    end

    // Stage B: optional rounding offset, arithmetic shift, then saturation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        q_sat_b = q_b[OutputWidth-1:0];
        sat_b   = 1'b0;
`ifdef FIR_OUT_ROUND_EN
        sum_b = $signed({a_q[AccWidth-1], a_q}) + RoundOff;
`else
        sum_b = $signed({a_q[AccWidth-1], a_q});
`endif
        q_b = sum_b >>> Shift;
        if (q_b > MaxQ) begin
            q_sat_b = {1'b0, {(OutputWidth - 1){1'b1}}};
            sat_b   = 1'b1;
        end else if (q_b < MinQ) begin
            q_sat_b = {1'b1, {(OutputWidth - 1){1'b0}}};
            sat_b   = 1'b1;
        end else begin
            q_sat_b = q_b[OutputWidth-1:0];
        end
        push_word = {sat_b, q_sat_b};
    end

    // FIFO next-state: push/pop arbitration, occupancy, overflow and the next head.
    always_comb begin
        push   = a_valid_q && !flush;
        pop    = (level_q != '0) && dout_ready && !flush;
        full   = (level_q == DepthLvl);
        // A push into a full FIFO is still taken when a pop frees a slot on the same edge.
        accept = push && (!full || pop);
        drop   = push && full && !pop;

        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (accept && !pop) begin
                level_d = level_q + LvlW'(1);
            end else if (pop && !accept) begin
                level_d = level_q - LvlW'(1);
            end
        end

        // A new drop overrides a clear requested on the same edge.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // The next head is either a stored entry or the word being written into that slot.
        head_idx = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        if (accept && (head_idx == wr_ptr_q)) begin
            head_word = push_word;
        end else begin
            head_word = mem_q[head_idx];
        end
        // dout holds its last value while the FIFO is empty.
        out_d = (level_d != '0) ? head_word : out_q;
    end

    // FIFO storage: written only on an accepted push.
    // NOTE: the storage array has no reset; level and the pointers decide
    // which entries are valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // FIFO control registers and registered head output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
        end
    end

    assign dout       = out_q[OutputWidth-1:0];
    assign dout_sat   = out_q[OutputWidth];
    assign dout_valid = (level_q != '0);
    assign level      = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Testbench for fir_output_stage: directed cases plus randomized traffic,
// checked against a queue-based reference model. The model follows the
// FIR_OUT_ROUND_EN build option in the same way as the design.
module tb_fir_output_stage;

    localparam int ACC_W = 38;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct {
        int val;
        bit sat;
    } sample_t;

    logic             clk;
    logic             rst;
    logic [ACC_W-1:0] acc_in;
    logic             acc_valid;
    logic             flush;
    logic             clr_ovf;
    logic [OUT_W-1:0] dout;
    logic             dout_sat;
    logic             dout_valid;
    logic             dout_ready;
    logic [LVL_W-1:0] level;
    logic             overflow;

    longint acc_val;

    // Reference model state.
    sample_t mq[$];
    bit      m_pend;
    longint  m_pend_val;
    bit      m_ovf;
    int      m_dout;
    bit      m_sat;

    int checks;
    int failures;

    fir_output_stage #(
        .AccWidth   (ACC_W),
        .OutputWidth(OUT_W),
        .Shift      (SHIFT),
        .Depth      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .dout      (dout),
        .dout_sat  (dout_sat),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scale a signed accumulator value to a saturated output sample.
    function automatic sample_t convert(input longint a);
        sample_t s;
        longint  t;
        longint  max_v;
        longint  min_v;
        t = a;
`ifdef FIR_OUT_ROUND_EN
        t = t + (longint'(1) <<< (SHIFT - 1));
`endif
        t     = t >>> SHIFT;
        max_v = (longint'(1) <<< (OUT_W - 1)) - 1;
        min_v = -(longint'(1) <<< (OUT_W - 1));
        s.sat = 1'b0;
        if (t > max_v) begin
            t     = max_v;
            s.sat = 1'b1;
        end else if (t < min_v) begin
            t     = min_v;
            s.sat = 1'b1;
        end
        s.val = int'(t);
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_ovf      = 1'b0;
        m_dout     = 0;
        m_sat      = 1'b0;
    endtask

    // One clock edge of the model, using the inputs the DUT sampled.
    task automatic model_edge();
        bit      full;
        bit      do_pop;
        bit      drop;
        sample_t s;
        drop = 1'b0;
        if (flush) begin
            mq.delete();
            m_pend = 1'b0;
            if (clr_ovf) m_ovf = 1'b0;
        end else begin
            full   = (mq.size() == DEPTH);
            do_pop = (mq.size() > 0) && dout_ready;
            if (do_pop) void'(mq.pop_front());
            if (m_pend) begin
                s = convert(m_pend_val);
                if (!full || do_pop) mq.push_back(s);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_pend     = acc_valid;
            m_pend_val = acc_val;
        end
        if (mq.size() > 0) begin
            m_dout = mq[0].val;
            m_sat  = mq[0].sat;
        end
    endtask

    task automatic compare();
        check("dout_valid", longint'(dout_valid), longint'(mq.size() > 0));
        check("level", longint'(level), longint'(mq.size()));
        check("overflow", longint'(overflow), longint'(m_ovf));
        check("dout", longint'($signed(dout)), longint'(m_dout));
        check("dout_sat", longint'(dout_sat), longint'(m_sat));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        compare();
    endtask

    task automatic drive(input bit v, input longint x);
        acc_valid = v;
        acc_val   = x;
        acc_in    = x[ACC_W-1:0];
    endtask

    function automatic longint rand_acc();
        longint r;
        int     bits;
        r = longint'({$urandom(), $urandom()});
        case ($urandom_range(0, 4))
            0: bits = 17;
            1: bits = 31;
            2: bits = 33;
            3: bits = ACC_W;
            default: bits = 0;
        endcase
        if (bits == 0) begin
            // Near the saturation threshold, either sign.
            r = (longint'(32767) <<< SHIFT) + longint'($urandom_range(0, 80000)) - 40000;
            if ($urandom_range(0, 1) == 1) r = -r;
        end else begin
            r = (r <<< (64 - bits)) >>> (64 - bits);
        end
        return r;
    endfunction

    // Single sample into an empty FIFO: not visible one cycle later, visible two cycles later.
    task automatic directed(input string tag, input longint v, input int exp_d, input bit exp_s);
        dout_ready = 1'b1;
        drive(1'b1, v);
        step();
        drive(1'b0, 0);
        check({tag, "_n1_valid"}, longint'(dout_valid), 0);
        step();
        check({tag, "_n2_valid"}, longint'(dout_valid), 1);
        check({tag, "_dout"}, longint'($signed(dout)), longint'(exp_d));
        check({tag, "_sat"}, longint'(dout_sat), longint'(exp_s));
        step();
    endtask

    // Strobe k*32768 for k = 1..n with the consumer stalled.
    task automatic fill(input int n);
        dout_ready = 1'b0;
        for (int k = 1; k <= n; k++) begin
            drive(1'b1, longint'(k) * 32768);
            step();
        end
        drive(1'b0, 0);
        step();
        step();
    endtask

    initial begin
        int exp_tail[4];
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        acc_in     = '0;
        acc_val    = 0;
        acc_valid  = 1'b0;
        flush      = 1'b0;
        clr_ovf    = 1'b0;
        dout_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        model_reset();
        check("rst_dout", longint'(dout), 0);
        check("rst_sat", longint'(dout_sat), 0);
        check("rst_valid", longint'(dout_valid), 0);
        check("rst_level", longint'(level), 0);
        check("rst_ovf", longint'(overflow), 0);
        #9 rst = 1'b1;

        // Rounding / truncation and saturation, each with its N+2 latency.
`ifdef FIR_OUT_ROUND_EN
        directed("rnd_16384", 16384, 1, 1'b0);
        directed("rnd_16383", 16383, 0, 1'b0);
        directed("rnd_m16384", -16384, 0, 1'b0);
`else
        directed("trn_16384", 16384, 0, 1'b0);
        directed("trn_m1", -1, -1, 1'b0);
        directed("trn_32768", 32768, 1, 1'b0);
`endif
        directed("sat_pos", longint'(1) <<< 31, 32767, 1'b1);
        directed("sat_neg", -(longint'(1) <<< 32), -32768, 1'b1);

        // Overflow: five results into a four-entry FIFO, the fifth is lost.
        fill(5);
        check("ovf_level", longint'(level), 4);
        check("ovf_flag", longint'(overflow), 1);
        dout_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain", longint'($signed(dout)), longint'(k));
            step();
        end
        check("ovf_empty", longint'(dout_valid), 0);
        check("ovf_still_set", longint'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", longint'(overflow), 0);

        // Full FIFO: push and pop on the same edge keep it full without a drop.
        fill(4);
        check("full_level", longint'(level), 4);
        drive(1'b1, longint'(7) * 32768);
        step();
        drive(1'b0, 0);
        dout_ready = 1'b1;
        step();
        check("pp_level", longint'(level), 4);
        check("pp_ovf", longint'(overflow), 0);
        exp_tail = '{2, 3, 4, 7};
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", longint'($signed(dout)), longint'(exp_tail[i]));
            step();
        end
        check("pp_empty", longint'(level), 0);

        // Flush: overflow survives, pipeline and FIFO contents are discarded.
        fill(5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_ovf_kept", longint'(overflow), 1);
        drive(1'b1, 32768);
        step();
        drive(1'b1, 65536);
        step();
        drive(1'b1, 98304);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 0);
        check("fl_valid", longint'(dout_valid), 0);
        check("fl_level", longint'(level), 0);
        check("fl_ovf", longint'(overflow), 1);
        step();
        step();
        check("fl_discard", longint'(level), 0);

        // Asynchronous reset in the middle of a cycle with buffered data.
        fill(3);
        drive(1'b1, longint'(9) * 32768);
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_dout", longint'(dout), 0);
        check("arst_sat", longint'(dout_sat), 0);
        check("arst_valid", longint'(dout_valid), 0);
        check("arst_level", longint'(level), 0);
        check("arst_ovf", longint'(overflow), 0);
        drive(1'b0, 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        step();
        check("arst_after", longint'(level), 0);

        // Randomized traffic with occasional flush and overflow clear.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 6, rand_acc());
            dout_ready = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 63) == 0);
            clr_ovf    = ($urandom_range(0, 31) == 0);
            step();
        end
        drive(1'b0, 0);
        flush   = 1'b0;
        clr_ovf = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
